serneg_sched: RTL and testbench

//  Shares one bit-serial two's-complement negation core between two parallel-word requesters.
//  - Arbitrates between the requesters round-robin.
//  - Restarts the core at the start of each word (core returns to its COPY state).
//  - Shifts the granted word into the core LSB-first and collects the serial result.
//  - Returns the negated word with the ID of the requester that issued it.

---
 rtl/serneg_if.sv | 24 ++
 rtl/serneg_sched.sv | 112 +++++++++++
 tb/tb_serneg_sched.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/serneg_if.sv
// Requester/result handshake bundle for serneg_sched.
// The master drives requests and out_ready; the slave is the scheduler.
interface serneg_if #(
  parameter int WIDTH = 8
);
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_id;

  modport master (
    output req_valid, req_data0, req_data1, out_ready,
    input  req_ready, out_valid, out_data, out_id
  );

  modport slave (
    input  req_valid, req_data0, req_data1, out_ready,
    output req_ready, out_valid, out_data, out_id
  );
endinterface

// File: rtl/serneg_sched.sv
// Round-robin scheduler sharing one Mealy bit-serial negation core between two requesters.
// Define SERNEG_OVF_EN to add the out_ovf flag (operand == 2^(WIDTH-1)).
module serneg_sched #(
  parameter int WIDTH = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  serneg_if.slave  bus,
  output logic     neg_clr,
  output logic     neg_x,
  input  logic     neg_z
`ifdef SERNEG_OVF_EN
  ,
  output logic     out_ovf
`endif
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, CLR, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic             ptr;
  logic             gnt_id;
  logic             take;
  logic             last_bit;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-2:0] res;
  logic [WIDTH-1:0] res_cat;

  // Pointer requester wins when valid; otherwise the other one gets the grant.
  assign gnt_id   = bus.req_valid[ptr] ? ptr : ~ptr;
  assign last_bit = (cnt == CNT_W'(WIDTH - 1));
  assign res_cat  = {neg_z, res};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    bus.out_valid = 1'b0;
    neg_clr       = 1'b1;
    neg_x         = 1'b0;
    take          = 1'b0;
    case (state)
      IDLE: begin
        if (bus.req_valid[gnt_id]) begin
          bus.req_ready[gnt_id] = 1'b1;
          take                  = 1'b1;
          state_nxt             = CLR;
        end
      end
      CLR: state_nxt = SHIFT;
      SHIFT: begin
        neg_clr = 1'b0;
        neg_x   = shreg[0];
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr          <= 1'b0;
      cnt          <= '0;
      bus.out_id   <= 1'b0;
      bus.out_data <= '0;
    end else begin
      if (take) begin
        ptr        <= ~gnt_id;
        bus.out_id <= gnt_id;
      end
      if (state == CLR)        cnt <= '0;
      else if (state == SHIFT) cnt <= cnt + 1'b1;
      if (state == SHIFT && last_bit) bus.out_data <= res_cat;
    end
  end

  // Operand goes out LSB-first; result bits enter at the top and settle into place.
  always_ff @(posedge clk) begin
    if (take) begin
      shreg <= gnt_id ? bus.req_data1 : bus.req_data0;
    end else if (state == SHIFT) begin
      shreg <= shreg >> 1;
      res   <= res_cat[WIDTH-1:1];
    end
  end

`ifdef SERNEG_OVF_EN
  logic [WIDTH-1:0] opnd;

  function automatic logic is_ovf(input logic [WIDTH-1:0] v);
    return v == {1'b1, {(WIDTH-1){1'b0}}};
  endfunction

  always_ff @(posedge clk) begin
    if (take) opnd <= gnt_id ? bus.req_data1 : bus.req_data0;
  end

  assign out_ovf = bus.out_valid && is_ovf(opnd);
`endif

endmodule

// File: tb/tb_serneg_sched.sv
// Directed bench for serneg_sched with a behavioural Mealy negation core model.
module tb_serneg_sched;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic neg_clr, neg_x, neg_z;
`ifdef SERNEG_OVF_EN
  logic out_ovf;
`endif

  serneg_if #(.WIDTH(WIDTH)) bus ();

  serneg_sched #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus.slave),
    .neg_clr (neg_clr),
    .neg_x   (neg_x),
    .neg_z   (neg_z)
`ifdef SERNEG_OVF_EN
    ,
    .out_ovf (out_ovf)
`endif
  );

  always #5 clk = ~clk;

  // Core: copy bits up to and including the first 1, invert afterwards.
  logic inv = 1'b0;
  always @(posedge clk) begin
    if (neg_clr)    inv <= 1'b0;
    else if (neg_x) inv <= 1'b1;
  end
  assign neg_z = inv ? ~neg_x : neg_x;

  typedef struct {
    logic       id;
    logic [7:0] d;
  } res_t;

  int   nvec = 0;
  int   nerr = 0;
  int   restarts = 0;
  logic prev_clr = 1'b1;
  logic xq[$];
  res_t rq[$];

  always @(negedge clk) begin
    res_t r;
    if (!neg_clr) xq.push_back(neg_x);
    if (prev_clr && !neg_clr) restarts++;
    prev_clr = neg_clr;
    if (bus.out_valid && bus.out_ready) begin
      r.id = bus.out_id;
      r.d  = bus.out_data;
      rq.push_back(r);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_word(input int rq_i, input logic [7:0] d, input logic [7:0] exp,
                         input int hold, input bit poke, input bit exp_ovf);
    int lat;
    bit got;
    @(posedge clk); #1;
    bus.req_valid[rq_i] = 1'b1;
    if (rq_i == 0) bus.req_data0 = d;
    else           bus.req_data1 = d;
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus.req_ready[rq_i]) got = 1;
    end
    chk("accept", got, 1);
    if (!got) begin
      bus.req_valid[rq_i] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    bus.req_valid[rq_i] = 1'b0;
    lat = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.out_valid) got = 1;
    end
    chk("done_seen", got, 1);
    chk("latency", lat, WIDTH + 1);
    chk("data", bus.out_data, exp);
    chk("id", bus.out_id, rq_i);
`ifdef SERNEG_OVF_EN
    chk("ovf", out_ovf, exp_ovf);
`else
    if (exp_ovf) chk("ovf_expected_without_port", 0, 0);
`endif
    if (poke) bus.req_valid[1-rq_i] = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_data", bus.out_data, exp);
      chk("hold_id", bus.out_id, rq_i);
      chk("hold_rdy", bus.req_ready, 0);
    end
    @(posedge clk); #1;
    if (poke) bus.req_valid[1-rq_i] = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    chk("released", bus.out_valid, 0);
  endtask

  initial begin
    int   cnt_s;
    int   seen;
    logic [7:0] xs;
    bus.req_valid = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.out_ready = 1'b0;

    #12;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_id", bus.out_id, 0);
    chk("rst_neg_clr", neg_clr, 1);
    chk("rst_neg_x", neg_x, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single word and its serial operand stream
    @(posedge clk); #1;
    xq.delete();
    do_word(0, 8'h05, 8'hFB, 0, 0, 0);
    xs = 8'b0000_0101;
    chk("negx_count", xq.size(), 8);
    for (int i = 0; i < 8; i++)
      chk($sformatf("negx_%0d", i), (i < xq.size()) ? xq[i] : 1'bx, xs[i]);

    // Corner values
    do_word(0, 8'h00, 8'h00, 0, 0, 0);
    do_word(1, 8'hFF, 8'h01, 0, 0, 0);
    do_word(0, 8'h80, 8'h80, 0, 0, 1);
    do_word(1, 8'h7F, 8'h81, 0, 0, 0);

    // Backpressure with the other requester knocking
    do_word(0, 8'h3C, 8'hC4, 5, 1, 0);

    // Back-to-back words need a core restart each
    cnt_s = restarts;
    do_word(1, 8'h04, 8'hFC, 0, 0, 0);
    do_word(1, 8'h04, 8'hFC, 0, 0, 0);
    chk("restarts", restarts - cnt_s, 2);

    // Reset in the middle of SHIFT
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b1;
    bus.req_data1    = 8'h5A;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      @(negedge clk);
      if (bus.req_ready[1]) seen = 1;
    end
    chk("accept_5a", seen, 1);
    @(posedge clk); #1;
    bus.req_valid[1] = 1'b0;
    cnt_s = 0;
    for (int k = 0; k < 20 && cnt_s < 4; k++) begin
      @(negedge clk);
      if (!neg_clr) cnt_s++;
    end
    chk("reached_bit3", cnt_s, 4);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_req_ready", bus.req_ready, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_out_id", bus.out_id, 0);
    chk("mid_rst_neg_clr", neg_clr, 1);
    chk("mid_rst_neg_x", neg_x, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk("no_stale_result", seen, 0);
    do_word(1, 8'h03, 8'hFD, 0, 0, 0);

    // Contention: alternating grants starting at requester 0
    @(posedge clk); #1;
    rq.delete();
    bus.out_ready = 1'b1;
    bus.req_data0 = 8'h01;
    bus.req_data1 = 8'h02;
    bus.req_valid = 2'b11;
    for (int k = 0; k < 200 && rq.size() < 4; k++) @(negedge clk);
    @(posedge clk); #1;
    bus.req_valid = 2'b00;
    bus.out_ready = 1'b0;
    chk("cont_count", (rq.size() >= 4) ? 4 : rq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rq.size()) begin
        chk($sformatf("cont_id_%0d", i), rq[i].id, i % 2);
        chk($sformatf("cont_data_%0d", i), rq[i].d, (i % 2 == 0) ? 8'hFF : 8'hFE);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
